axis_window_pad: RTL and testbench

AXIS_WINDOW_PAD -- requirements
Module: axis_window_pad

---
 rtl/axis_window_pad.sv | 228 ++++++++++++++++++++++
 tb/tb_axis_window_pad.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_window_pad.sv
// rtl/axis_window_pad.sv - crop/pad window extractor for a raster pixel stream
//
// Purpose: cuts a win_width x win_height window at (win_left, win_top) out of
// an ori_width x ori_height source raster. Window pixels that fall outside the
// source image are filled with pad_value. Geometry is captured on the frame
// start beat and held for the whole frame.
//
// Ports:
//   clk, resetn                    clock, synchronous active-low reset
//   ori_width/ori_height           source image size
//   win_left/win_top               window origin in source coordinates
//   win_width/win_height           window (output) size
//   pad_value                      fill value for out-of-image pixels
//   s_axis_*                       source pixel stream (tuser = start of frame)
//   m_axis_*                       window pixel stream (tuser = first pixel,
//                                  tlast = last pixel of each window row)
//   frame_done                     one-cycle pulse when a frame completes
module axis_window_pad #(
   parameter int C_PIXEL_WIDTH = 8,
   parameter int C_IMG_WBITS   = 12,
   parameter int C_IMG_HBITS   = 12
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [C_IMG_WBITS-1:0]   ori_width,
   input  logic [C_IMG_HBITS-1:0]   ori_height,
   input  logic [C_IMG_WBITS-1:0]   win_left,
   input  logic [C_IMG_HBITS-1:0]   win_top,
   input  logic [C_IMG_WBITS-1:0]   win_width,
   input  logic [C_IMG_HBITS-1:0]   win_height,
   input  logic [C_PIXEL_WIDTH-1:0] pad_value,
   input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   input  logic                     s_axis_tuser,
   input  logic                     s_axis_tlast,
   output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic                     m_axis_tuser,
   output logic                     m_axis_tlast,
   output logic                     frame_done
);
   typedef enum logic [1:0] {S_IDLE, S_PASS, S_PADC, S_PADR} state_t;

   localparam logic [C_IMG_WBITS-1:0] W_ONE = C_IMG_WBITS'(1);
   localparam logic [C_IMG_HBITS-1:0] H_ONE = C_IMG_HBITS'(1);
   localparam logic [C_IMG_WBITS:0]   P_ONE = (C_IMG_WBITS+1)'(1);

   state_t                   state;
   logic                     run;
   logic                     src_done;
   logic [C_IMG_WBITS-1:0]   l_ori_w, l_left, l_ww;
   logic [C_IMG_HBITS-1:0]   l_ori_h, l_top, l_wh;
   logic [C_PIXEL_WIDTH-1:0] l_pad;
   logic [C_IMG_WBITS-1:0]   src_col, out_col;
   logic [C_IMG_HBITS-1:0]   src_row, out_row;
   logic [C_IMG_WBITS:0]     pad_cnt;

   logic [C_IMG_WBITS-1:0]   p_ori_w, p_left, p_ww, edge_col;
   logic [C_IMG_HBITS-1:0]   p_ori_h, p_top, p_wh;
   logic [C_IMG_WBITS:0]     win_right, padc_len;
   logic [C_IMG_HBITS:0]     win_bottom;
   logic                     out_free, take, row_in_win, col_in_win;
   logic                     end_col, end_row, need_padc, rows_left;
   logic                     out_last, out_first, load;
   logic [C_PIXEL_WIDTH-1:0] load_data;
   logic                     unused_tlast;

   // Source position comes from the internal counters only.
   assign unused_tlast = s_axis_tlast;

   // The frame-start beat is processed as source (0,0) on the same edge that
   // latches the geometry, so in IDLE the live inputs are used directly.
   assign p_ori_w = (state == S_IDLE) ? ori_width  : l_ori_w;
   assign p_ori_h = (state == S_IDLE) ? ori_height : l_ori_h;
   assign p_left  = (state == S_IDLE) ? win_left   : l_left;
   assign p_top   = (state == S_IDLE) ? win_top    : l_top;
   assign p_ww    = (state == S_IDLE) ? win_width  : l_ww;
   assign p_wh    = (state == S_IDLE) ? win_height : l_wh;

   assign out_free = !m_axis_tvalid || m_axis_tready;

   always_comb begin
      s_axis_tready = 1'b0;
      case (state)
         S_IDLE:  s_axis_tready = run;
         S_PASS:  s_axis_tready = !src_done && out_free;
         default: s_axis_tready = 1'b0;
      endcase
   end

   // Non-tuser beats in IDLE are accepted but dropped.
   assign take = s_axis_tvalid && s_axis_tready && (state != S_IDLE || s_axis_tuser);

   assign win_right  = {1'b0, p_left} + {1'b0, p_ww};
   assign win_bottom = {1'b0, p_top} + {1'b0, p_wh};
   assign row_in_win = (src_row >= p_top) && ({1'b0, src_row} < win_bottom);
   assign col_in_win = (src_col >= p_left) && ({1'b0, src_col} < win_right);
   assign end_col    = (src_col == p_ori_w - W_ONE);
   assign end_row    = (src_row == p_ori_h - H_ONE);

   // Right-edge pad starts where the image ends, or at the window origin when
   // the whole window lies right of the image.
   assign edge_col  = (p_ori_w > p_left) ? p_ori_w : p_left;
   assign need_padc = row_in_win && (p_ww != '0) && (win_right > {1'b0, p_ori_w});
   assign padc_len  = win_right - {1'b0, edge_col};

   // Window rows still owed once the source is exhausted lie below the image.
   assign rows_left = (p_ww != '0) && (out_row < p_wh);

   assign out_last  = ({1'b0, out_col} + {1'b0, W_ONE}) == {1'b0, p_ww};
   assign out_first = (out_row == '0) && (out_col == '0);

   assign load = (take && row_in_win && col_in_win)
              || (state == S_PADC && out_free)
              || (state == S_PADR && out_free && rows_left);
   assign load_data = (state == S_PADC || state == S_PADR) ? l_pad : s_axis_tdata;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state         <= S_IDLE;
         run           <= 1'b0;
         src_done      <= 1'b0;
         l_ori_w       <= '0;
         l_ori_h       <= '0;
         l_left        <= '0;
         l_top         <= '0;
         l_ww          <= '0;
         l_wh          <= '0;
         l_pad         <= '0;
         src_col       <= '0;
         src_row       <= '0;
         out_col       <= '0;
         out_row       <= '0;
         pad_cnt       <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tuser  <= 1'b0;
         m_axis_tlast  <= 1'b0;
         frame_done    <= 1'b0;
      end else begin
         run        <= 1'b1;
         frame_done <= 1'b0;
         if (m_axis_tvalid && m_axis_tready)
            m_axis_tvalid <= 1'b0;

         case (state)
            S_IDLE: begin
               if (take) begin
                  l_ori_w <= ori_width;
                  l_ori_h <= ori_height;
                  l_left  <= win_left;
                  l_top   <= win_top;
                  l_ww    <= win_width;
                  l_wh    <= win_height;
                  l_pad   <= pad_value;
                  state   <= S_PASS;
               end
            end
            S_PASS: begin
               // Source exhausted: wait for the output slot, then pad or finish.
               if (src_done && out_free) begin
                  if (rows_left) begin
                     state <= S_PADR;
                  end else begin
                     state      <= S_IDLE;
                     frame_done <= 1'b1;
                     src_done   <= 1'b0;
                     src_col    <= '0;
                     src_row    <= '0;
                     out_col    <= '0;
                     out_row    <= '0;
                  end
               end
            end
            S_PADC: begin
               if (out_free) begin
                  pad_cnt <= pad_cnt - P_ONE;
                  if (pad_cnt == P_ONE)
                     state <= S_PASS;
               end
            end
            S_PADR: begin
               if (out_free && !rows_left) begin
                  state      <= S_IDLE;
                  frame_done <= 1'b1;
                  src_done   <= 1'b0;
                  src_col    <= '0;
                  src_row    <= '0;
                  out_col    <= '0;
                  out_row    <= '0;
               end
            end
            default: state <= S_IDLE;
         endcase

         if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= load_data;
            m_axis_tuser  <= out_first;
            m_axis_tlast  <= out_last;
            if (out_last) begin
               out_col <= '0;
               out_row <= out_row + H_ONE;
            end else begin
               out_col <= out_col + W_ONE;
            end
         end

         if (take) begin
            if (end_col) begin
               src_col <= '0;
               if (end_row)
                  src_done <= 1'b1;
               else
                  src_row <= src_row + H_ONE;
               if (need_padc) begin
                  state   <= S_PADC;
                  pad_cnt <= padc_len;
               end
            end else begin
               src_col <= src_col + W_ONE;
            end
         end
      end
   end
endmodule

// File: tb/tb_axis_window_pad.sv
// tb/tb_axis_window_pad.sv - self-checking bench for axis_window_pad
module tb_axis_window_pad;
   logic        clk = 1'b0;
   logic        resetn;
   logic [11:0] ori_width, ori_height, win_left, win_top, win_width, win_height;
   logic [7:0]  pad_value;
   logic [7:0]  s_tdata;
   logic        s_tvalid, s_tready, s_tuser, s_tlast;
   logic [7:0]  m_tdata;
   logic        m_tvalid, m_tready, m_tuser, m_tlast;
   logic        frame_done;

   always #5 clk = ~clk;

   axis_window_pad dut (
      .clk(clk), .resetn(resetn),
      .ori_width(ori_width), .ori_height(ori_height),
      .win_left(win_left), .win_top(win_top),
      .win_width(win_width), .win_height(win_height),
      .pad_value(pad_value),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast),
      .frame_done(frame_done)
   );

   typedef struct {
      logic [7:0] d;
      logic       u;
      logic       l;
   } beat_t;

   beat_t      exp_q[$];
   logic [7:0] mem [0:255];
   int         total = 0;
   int         bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic scramble_geometry();
      ori_width  = 12'($urandom);
      ori_height = 12'($urandom);
      win_left   = 12'($urandom);
      win_top    = 12'($urandom);
      win_width  = 12'($urandom);
      win_height = 12'($urandom);
      pad_value  = 8'($urandom);
   endtask

   // Drives one frame (optional dropped preamble) with random valid/ready and
   // compares every output beat with the window built from the raster.
   task automatic run_frame(input int ow, input int oh, input int wl, input int wt,
                            input int ww, input int wh, input logic [7:0] pad,
                            input int npre, input int abort_after, input int stall_at,
                            input bit pat, input int exp_beats);
      int  n_src, si, got, cyc, done_cnt, stall_left, sr, sc;
      bit  scram, have;
      beat_t b;
      exp_q.delete();
      for (int r = 0; r < oh; r++)
         for (int c = 0; c < ow; c++)
            mem[r*ow+c] = pat ? 8'(r*16+c) : 8'($urandom);
      for (int r = 0; r < wh; r++)
         for (int c = 0; c < ww; c++) begin
            sr = wt + r;
            sc = wl + c;
            b.d = (sr < oh && sc < ow) ? mem[sr*ow+sc] : pad;
            b.u = (r == 0 && c == 0);
            b.l = (c == ww - 1);
            exp_q.push_back(b);
         end
      ori_width = 12'(ow); ori_height = 12'(oh);
      win_left = 12'(wl); win_top = 12'(wt);
      win_width = 12'(ww); win_height = 12'(wh);
      pad_value = pad;
      n_src = npre + ow*oh;
      si = 0; got = 0; cyc = 0; done_cnt = 0; stall_left = 0; scram = 0;
      while (1) begin
         @(negedge clk);
         if (scram) begin
            scramble_geometry();
            scram = 0;
         end
         if (si < n_src && $urandom_range(0, 3) != 0) begin
            s_tvalid = 1'b1;
            if (si < npre) begin
               s_tdata = 8'($urandom);
               s_tuser = 1'b0;
            end else begin
               s_tdata = mem[si-npre];
               s_tuser = (si == npre) ? 1'b1 : 1'($urandom);
            end
         end else begin
            s_tvalid = 1'b0;
            s_tuser  = 1'($urandom);
         end
         s_tlast = 1'($urandom);
         if (stall_left > 0) begin
            m_tready = 1'b0;
            stall_left--;
         end else begin
            m_tready = ($urandom_range(0, 3) != 0);
         end
         #1;
         if (frame_done) begin
            done_cnt++;
            chk("done_after_last_beat", exp_q.size(), 0);
            chk("done_src_consumed", si, n_src);
         end
         if (m_tvalid && m_tready) begin
            have = (exp_q.size() != 0);
            chk("beat_expected", have, 1);
            if (have) begin
               b = exp_q.pop_front();
               chk("tdata", m_tdata, b.d);
               chk("tuser", m_tuser, b.u);
               chk("tlast", m_tlast, b.l);
            end
            got++;
            if (got == stall_at) stall_left = 10;
         end else if (m_tvalid && !m_tready && exp_q.size() != 0) begin
            chk("hold_tdata", m_tdata, exp_q[0].d);
            chk("hold_tuser", m_tuser, exp_q[0].u);
            chk("hold_tlast", m_tlast, exp_q[0].l);
         end
         if (s_tvalid && s_tready) begin
            if (si == npre) scram = 1;
            si++;
         end
         cyc++;
         if (abort_after >= 0 && got == abort_after) break;
         if (si == n_src && exp_q.size() == 0 && done_cnt > 0) break;
         if (cyc > 6000) break;
      end
      s_tvalid = 1'b0;
      if (abort_after < 0) begin
         repeat (3) begin
            @(negedge clk);
            #1;
            if (frame_done) done_cnt++;
            chk("idle_no_valid", m_tvalid, 0);
         end
         chk("src_consumed", si, n_src);
         chk("beats_left", exp_q.size(), 0);
         chk("beat_count", got, exp_beats);
         chk("frame_done_count", done_cnt, 1);
      end
   endtask

   initial begin
      int ow, oh, wl, wt, ww, wh;
      resetn = 1'b0;
      s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0;
      m_tready = 1'b1;
      scramble_geometry();

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_s_tready", s_tready, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tuser", m_tuser, 0);
      chk("rst_m_tlast", m_tlast, 0);
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_frame_done", frame_done, 0);
      resetn = 1'b1;
      @(negedge clk);
      #1;
      chk("idle_s_tready", s_tready, 1);

      // Interior window
      run_frame(16, 16, 3, 3, 5, 6, 8'h55, 0, -1, -1, 1, 30);
      // Window crossing right and bottom edges
      run_frame(16, 16, 14, 13, 4, 5, 8'hAA, 0, -1, -1, 1, 20);
      // Empty window then interior window on consecutive frames
      run_frame(16, 16, 3, 3, 0, 0, 8'h11, 0, -1, -1, 1, 0);
      run_frame(16, 16, 3, 3, 5, 6, 8'h55, 0, -1, -1, 1, 30);
      // Ten-cycle output stall mid-row
      run_frame(16, 16, 3, 3, 5, 6, 8'h55, 0, -1, 8, 1, 30);

      // Preamble beats, then reset after 7 output beats
      run_frame(16, 16, 3, 3, 5, 6, 8'h55, 3, 7, -1, 1, 30);
      @(negedge clk);
      resetn = 1'b0;
      m_tready = 1'b1;
      @(negedge clk);
      #1;
      chk("midrst_m_tvalid", m_tvalid, 0);
      chk("midrst_s_tready", s_tready, 0);
      chk("midrst_frame_done", frame_done, 0);
      resetn = 1'b1;
      @(negedge clk);
      #1;
      chk("postrst_m_tvalid", m_tvalid, 0);
      chk("postrst_s_tready", s_tready, 1);
      run_frame(16, 16, 3, 3, 5, 6, 8'h55, 3, -1, -1, 1, 30);

      // Degenerate: zero width with nonzero height, window fully off-image
      run_frame(8, 6, 2, 1, 0, 4, 8'h22, 0, -1, -1, 0, 0);
      run_frame(8, 6, 10, 7, 3, 2, 8'h33, 1, -1, -1, 0, 6);

      // Random geometry and data
      for (int k = 0; k < 10; k++) begin
         ow = $urandom_range(1, 12);
         oh = $urandom_range(1, 12);
         wl = $urandom_range(0, 14);
         wt = $urandom_range(0, 14);
         ww = $urandom_range(0, 6);
         wh = $urandom_range(0, 6);
         run_frame(ow, oh, wl, wt, ww, wh, 8'($urandom), $urandom_range(0, 2), -1,
                   ($urandom_range(0, 1) != 0) ? 3 : -1, 0, ww*wh);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
